// File: rtl/ssp_pkg.sv
// Shared constants, state encoding and frame packing
// for the SSP/SPI master.
package ssp_pkg;

  localparam int FRAME_LEN = 16;
  localparam int RA_MSB    = 15;
  localparam int WNR_BIT   = 12;
  localparam int DATA_MSB  = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef logic [FRAME_LEN-1:0] frame_t;

  function automatic frame_t pack_frame(
    input logic [2:0]        ra,
    input logic              wnr,
    input logic [DATA_MSB:0] di
  );
    frame_t f;
    f = '0;
    f[RA_MSB -: 3] = ra;
    f[WNR_BIT]     = wnr;
    f[DATA_MSB:0]  = di;
    return f;
  endfunction

endpackage

// File: rtl/ssp_sck_gen.sv
// Half-period counter: phase tick, SCK and its edge strobes.
// SCK only toggles while toggle_en; it parks low when not running.
module ssp_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic toggle_en,
  output logic sck,
  output logic tick,
  output logic rise,
  output logic fall
);

  localparam logic [7:0] TOP = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign tick = run && (cnt == TOP);
  assign rise = tick && toggle_en && !sck;
  assign fall = tick && toggle_en && sck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      cnt <= '0;
      sck <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 8'd1;
      if (rise || fall) begin
        sck <= !sck;
      end
    end
  end

endmodule

// File: rtl/ssp_spi_master.sv
// SSP/SPI master: sends one RA/WnR/DI frame MSB first on MOSI
// and captures the slave reply from MISO (SPI mode 0).
module ssp_spi_master
  import ssp_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic [2:0]  RA,
  input  logic        WnR,
  input  logic [11:0] DI,
  input  logic        MISO,
  output logic        SSEL,
  output logic        SCK,
  output logic        MOSI,
  output logic        Busy,
  output logic        Done,
  output logic [11:0] DO
);

  localparam logic [4:0] LAST = 5'(FRAME_LEN);

  state_t            state_q, state_d;
  frame_t            sr_q, sr_d, req;
  logic [DATA_MSB:0] cap_q, cap_d, do_d;
  logic [4:0]        bits_q, bits_d;
  logic              ssel_d, busy_d, done_d;
  logic              run, shift_en;
  logic              tick, rise, fall;

  assign req      = pack_frame(RA, WnR, DI);
  assign run      = (state_q == ST_SETUP) ||
                    (state_q == ST_SHIFT) ||
                    (state_q == ST_HOLD);
  assign shift_en = (state_q == ST_SHIFT);

  // Left shift with zero fill leaves MOSI low once all bits are out.
  assign MOSI = sr_q[FRAME_LEN-1];

  ssp_sck_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sck (
    .clk      (Clk),
    .rst_n    (Rst),
    .run      (run),
    .toggle_en(shift_en),
    .sck      (SCK),
    .tick     (tick),
    .rise     (rise),
    .fall     (fall)
  );

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cap_d   = cap_q;
    bits_d  = bits_q;
    ssel_d  = SSEL;
    busy_d  = Busy;
    done_d  = 1'b0;
    do_d    = DO;
    if (rise) begin
      cap_d  = {cap_q[DATA_MSB-1:0], MISO};
      bits_d = bits_q + 5'd1;
    end
    unique case (state_q)
      ST_IDLE: begin
        if (Start) begin
          state_d = ST_SETUP;
          sr_d    = req;
          cap_d   = '0;
          bits_d  = '0;
          ssel_d  = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_SETUP: begin
        if (tick) begin
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (fall) begin
          sr_d = {sr_q[FRAME_LEN-2:0], 1'b0};
          if (bits_q == LAST) begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        if (tick) begin
          state_d = ST_DONE;
          ssel_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          do_d    = cap_q;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= ST_IDLE;
      sr_q    <= '0;
      cap_q   <= '0;
      bits_q  <= '0;
      SSEL    <= 1'b0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DO      <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cap_q   <= cap_d;
      bits_q  <= bits_d;
      SSEL    <= ssel_d;
      Busy    <= busy_d;
      Done    <= done_d;
      DO      <= do_d;
    end
  end

endmodule

// File: tb/tb_ssp_spi_master.sv
// Bench for ssp_spi_master: a CLK_DIV=2 and a CLK_DIV=1 instance,
// each with a mode-0 slave model, checked against frame-level expectations.
module tb_ssp_spi_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  ra;
  logic        wnr;
  logic [11:0] di;

  logic        start [2];
  logic        miso  [2];
  logic        ssel  [2];
  logic        sck   [2];
  logic        mosi  [2];
  logic        busy  [2];
  logic        done  [2];
  logic [11:0] dout  [2];

  logic [15:0] resp [2];
  logic [15:0] mw   [2];
  int rises  [2] = '{default: 0};
  int bad    [2] = '{default: 0};
  int dcount [2] = '{default: 0};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssp_spi_master #(.CLK_DIV(2)) dut2 (
    .Clk(clk), .Rst(rst_n), .Start(start[0]),
    .RA(ra), .WnR(wnr), .DI(di), .MISO(miso[0]),
    .SSEL(ssel[0]), .SCK(sck[0]), .MOSI(mosi[0]),
    .Busy(busy[0]), .Done(done[0]), .DO(dout[0])
  );

  ssp_spi_master #(.CLK_DIV(1)) dut1 (
    .Clk(clk), .Rst(rst_n), .Start(start[1]),
    .RA(ra), .WnR(wnr), .DI(di), .MISO(miso[1]),
    .SSEL(ssel[1]), .SCK(sck[1]), .MOSI(mosi[1]),
    .Busy(busy[1]), .Done(done[1]), .DO(dout[1])
  );

  // Slave: drives resp MSB first, advancing on SCK falls; records MOSI on rises
  // and flags any SCK phase whose length differs from the divider.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    localparam int DV = (g == 0) ? 2 : 1;
    logic p_ssel = 1'b0;
    logic p_sck  = 1'b0;
    int   k      = 0;
    time  t_last = 0;
    time  t_exp;

    always @(ssel[g] or sck[g]) begin
      if (ssel[g] === 1'b1 && !p_ssel) begin
        k        = 0;
        mw[g]    = '0;
        rises[g] = 0;
        t_last   = $time;
      end else if (ssel[g] === 1'b1 && sck[g] !== p_sck) begin
        t_exp = (sck[g] && rises[g] == 0) ? 2 * DV * 10 : DV * 10;
        if ($time - t_last != t_exp) bad[g]++;
        t_last = $time;
        if (sck[g]) begin
          mw[g] = {mw[g][14:0], mosi[g]};
          rises[g]++;
        end else begin
          k++;
        end
      end
      p_ssel  = (ssel[g] === 1'b1);
      p_sck   = (sck[g] === 1'b1);
      miso[g] = (ssel[g] === 1'b1 && k < 16) ? resp[g][15-k] : 1'b0;
    end

    always @(posedge clk) begin
      if (done[g] === 1'b1) dcount[g]++;
    end
  end

  function automatic int dv(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic string tg(input int i, input string s);
    return $sformatf("d%0d_%s", i, s);
  endfunction

  function automatic logic [15:0] frame_of(
    input logic [2:0] a, input logic w, input logic [11:0] d
  );
    return {a, w, d};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(
    input int i, input logic [2:0] a, input logic w,
    input logic [11:0] d, input logic [15:0] r, input bit hold
  );
    ra       = a;
    wnr      = w;
    di       = d;
    resp[i]  = r;
    start[i] = 1'b1;
    @(negedge clk);
    if (!hold) start[i] = 1'b0;
  endtask

  // Entered on the first negedge after the accept edge (cycle 1).
  task automatic expect_frame(
    input int i, input logic [15:0] f, input logic [15:0] r,
    input int pulse_at, input bit done_pulse
  );
    int cyc;
    int b0;
    cyc = 1;
    b0  = bad[i];
    chk(tg(i, "busy_on"), busy[i], 1);
    chk(tg(i, "ssel_on"), ssel[i], 1);
    chk(tg(i, "mosi_msb"), mosi[i], f[15]);
    ra  = 3'($urandom);
    wnr = 1'($urandom);
    di  = 12'($urandom);
    while (done[i] !== 1'b1 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (pulse_at != 0) start[i] = (cyc == pulse_at);
    end
    chk(tg(i, "done_cycle"), cyc, 34 * dv(i) + 1);
    chk(tg(i, "busy_at_done"), busy[i], 0);
    chk(tg(i, "ssel_at_done"), ssel[i], 0);
    chk(tg(i, "dout"), dout[i], r[11:0]);
    chk(tg(i, "mosi_word"), mw[i], f);
    chk(tg(i, "sck_rises"), rises[i], 16);
    chk(tg(i, "sck_phase"), bad[i], b0);
    if (done_pulse) start[i] = 1'b1;
    @(negedge clk);
    if (done_pulse) start[i] = 1'b0;
    chk(tg(i, "done_single"), done[i], 0);
    chk(tg(i, "ssel_idle"), ssel[i], 0);
  endtask

  initial begin
    logic [2:0]  a;
    logic        w;
    logic [11:0] d;
    logic [15:0] r, r2;
    logic [15:0] f2;
    int          dc0;
    int          wt;

    rst_n    = 1'b0;
    start[0] = 1'b0;
    start[1] = 1'b0;
    ra       = '0;
    wnr      = 1'b0;
    di       = '0;
    resp[0]  = '0;
    resp[1]  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk(tg(i, "rst_ssel"), ssel[i], 0);
      chk(tg(i, "rst_sck"), sck[i], 0);
      chk(tg(i, "rst_mosi"), mosi[i], 0);
      chk(tg(i, "rst_busy"), busy[i], 0);
      chk(tg(i, "rst_done"), done[i], 0);
      chk(tg(i, "rst_dout"), dout[i], 0);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write 3/1/A5C on both dividers
    for (int i = 0; i < 2; i++) begin
      r = 16'($urandom);
      launch(i, 3'b011, 1'b1, 12'hA5C, r, 1'b0);
      expect_frame(i, 16'h7A5C, r, 0, 1'b0);
    end

    // Directed read, slave answers 3C7
    d = 12'($urandom);
    r = {4'($urandom), 12'h3C7};
    launch(0, 3'b001, 1'b0, d, r, 1'b0);
    expect_frame(0, frame_of(3'b001, 1'b0, d), r, 0, 1'b0);

    // Random frames on both instances
    for (int n = 0; n < 3; n++) begin
      for (int i = 0; i < 2; i++) begin
        a = 3'($urandom);
        w = 1'($urandom);
        d = 12'($urandom);
        r = 16'($urandom);
        launch(i, a, w, d, r, 1'b0);
        expect_frame(i, frame_of(a, w, d), r, 0, 1'b0);
      end
    end

    // Back-to-back with Start held high
    a  = 3'($urandom);
    w  = 1'($urandom);
    d  = 12'($urandom);
    r  = 16'($urandom);
    launch(0, a, w, d, r, 1'b1);
    expect_frame(0, frame_of(a, w, d), r, 0, 1'b0);
    chk("b2b_idle_busy", busy[0], 0);
    a  = 3'($urandom);
    w  = 1'($urandom);
    d  = 12'($urandom);
    r2 = 16'($urandom);
    f2 = frame_of(a, w, d);
    ra = a;
    wnr = w;
    di = d;
    resp[0] = r2;
    @(negedge clk);
    start[0] = 1'b0;
    chk("b2b_one_idle_gap", ssel[0], 1);
    expect_frame(0, f2, r2, 0, 1'b0);

    // Start pulsed during SHIFT and during DONE
    dc0 = dcount[0];
    a = 3'($urandom);
    w = 1'($urandom);
    d = 12'($urandom);
    r = 16'($urandom);
    launch(0, a, w, d, r, 1'b0);
    expect_frame(0, frame_of(a, w, d), r, 40, 1'b1);
    repeat (4) @(negedge clk);
    chk("ignored_start_ssel", ssel[0], 0);
    chk("ignored_start_busy", busy[0], 0);
    chk("ignored_start_dones", dcount[0] - dc0, 1);

    // Reset after the 7th SCK rise
    a = 3'($urandom);
    w = 1'($urandom);
    d = 12'($urandom);
    r = 16'($urandom);
    launch(0, a, w, d, r, 1'b0);
    dc0 = dcount[0];
    wt  = 0;
    while (rises[0] < 7 && wt < 300) begin
      @(negedge clk);
      wt++;
    end
    chk("rise7_reached", rises[0], 7);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_ssel", ssel[0], 0);
    chk("async_rst_sck", sck[0], 0);
    chk("async_rst_busy", busy[0], 0);
    chk("async_rst_mosi", mosi[0], 0);
    chk("async_rst_dout", dout[0], 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_ssel", ssel[0], 0);
    chk("post_rst_busy", busy[0], 0);
    chk("post_rst_no_done", dcount[0], dc0);

    a = 3'($urandom);
    w = 1'($urandom);
    d = 12'($urandom);
    r = 16'($urandom);
    launch(0, a, w, d, r, 1'b0);
    expect_frame(0, frame_of(a, w, d), r, 0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
